cas_fsk_player: RTL and testbench



---
 rtl/cas_fsk_player.sv | 173 +++++++++++++++++
 tb/tb_cas_fsk_player.sv | 376 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cas_fsk_player.sv
// Cassette FSK playback: fetches tape bytes from SRAM and plays them LSB-first as 1200/2400 Hz cycles.
// Optional CAS_AUTOREWIND_EN: rewind internally when the motor stops at end of tape.
module cas_fsk_player #(
  parameter int unsigned CLK_HZ = 57272727,
  parameter int unsigned RD_LAT = 2,
  parameter int unsigned AW     = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          en,
  input  logic          rewind,
  input  logic [AW-1:0] tape_len,
  output logic [AW-1:0] mem_addr,
  input  logic [7:0]    mem_data,
  output logic          casdout,
  output logic          busy,
  output logic          eot
);

  localparam int unsigned HALF0 = CLK_HZ / 2400;
  localparam int unsigned HALF1 = CLK_HZ / 4800;
  localparam int unsigned PW    = $clog2(HALF0 + 1);
  localparam int unsigned WW    = (RD_LAT < 1) ? 1 : $clog2(RD_LAT + 1);
  localparam logic [AW-1:0] ADDR_MAX = '1;

  typedef enum logic [1:0] {IDLE, FETCH, PLAY} state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [7:0]      shift_q, shift_d;
  logic [2:0]      bit_q, bit_d;
  logic [PW-1:0]   cnt_q, cnt_d;
  logic [WW-1:0]   wait_q, wait_d;
  logic            high_q, high_d;
  logic            cas_q, cas_d;
  logic            busy_q, busy_d;
  logic            eot_q, eot_d;
  logic [AW-1:0]   addr_nxt;
  logic            addr_last;

  function automatic logic [PW-1:0] half_load(input logic b);
    return b ? PW'(HALF1 - 1) : PW'(HALF0 - 1);
  endfunction

  // Address saturates at the top of the space, which also counts as end of tape.
  assign addr_nxt  = (addr_q == ADDR_MAX) ? addr_q : addr_q + AW'(1);
  assign addr_last = (addr_q == ADDR_MAX) || (addr_nxt >= tape_len);

`ifdef CAS_AUTOREWIND_EN
  logic en_q;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) en_q <= 1'b0;
    else       en_q <= en;
  end
`endif

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    shift_d = shift_q;
    bit_d   = bit_q;
    cnt_d   = cnt_q;
    wait_d  = wait_q;
    high_d  = high_q;
    cas_d   = cas_q;
    busy_d  = busy_q;
    eot_d   = eot_q;
    if (rewind) begin
      state_d = IDLE;
      addr_d  = '0;
      cas_d   = 1'b0;
      busy_d  = 1'b0;
      eot_d   = 1'b0;
`ifdef CAS_AUTOREWIND_EN
    end else if (eot_q && en_q && !en) begin
      state_d = IDLE;
      addr_d  = '0;
      eot_d   = 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (addr_q >= tape_len) begin
            eot_d = 1'b1;
          end else begin
            eot_d = 1'b0;
            if (en) begin
              state_d = FETCH;
              busy_d  = 1'b1;
              wait_d  = WW'(RD_LAT);
            end
          end
        end
        FETCH: begin
          if (en) begin
            if (wait_q == '0) begin
              shift_d = mem_data;
              bit_d   = 3'd0;
              cnt_d   = half_load(mem_data[0]);
              high_d  = 1'b1;
              cas_d   = 1'b1;
              state_d = PLAY;
            end else begin
              wait_d = wait_q - WW'(1);
            end
          end
        end
        PLAY: begin
          if (en) begin
            if (cnt_q != '0) begin
              cnt_d = cnt_q - PW'(1);
            end else if (high_q) begin
              high_d = 1'b0;
              cas_d  = 1'b0;
              cnt_d  = half_load(shift_q[0]);
            end else begin
              shift_d = shift_q >> 1;
              bit_d   = bit_q + 3'd1;
              if (bit_q == 3'd7) begin
                addr_d = addr_nxt;
                if (addr_last) begin
                  state_d = IDLE;
                  busy_d  = 1'b0;
                  eot_d   = 1'b1;
                end else begin
                  state_d = FETCH;
                  wait_d  = WW'(RD_LAT);
                end
              end else begin
                high_d = 1'b1;
                cas_d  = 1'b1;
                cnt_d  = half_load(shift_q[1]);
              end
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      shift_q <= '0;
      bit_q   <= '0;
      cnt_q   <= '0;
      wait_q  <= '0;
      high_q  <= 1'b0;
      cas_q   <= 1'b0;
      busy_q  <= 1'b0;
      eot_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      shift_q <= shift_d;
      bit_q   <= bit_d;
      cnt_q   <= cnt_d;
      wait_q  <= wait_d;
      high_q  <= high_d;
      cas_q   <= cas_d;
      busy_q  <= busy_d;
      eot_q   <= eot_d;
    end
  end

  assign mem_addr = addr_q;
  assign casdout  = cas_q;
  assign busy     = busy_q;
  assign eot      = eot_q;

endmodule

// File: tb/tb_cas_fsk_player.sv
// Bench for cas_fsk_player: a monitor measures each bit's high/low run in active cycles
// and checks it against a queue of expected half-lengths built from the tape contents.
module tb_cas_fsk_player;
  localparam int unsigned CLK_HZ = 48000;
  localparam int unsigned RD_LAT = 2;
  localparam int unsigned AW     = 16;
  localparam int H0  = 20;
  localparam int H1  = 10;
  localparam int GAP = 3;

  logic          clk = 1'b0;
  logic          reset, en, rewind;
  logic [AW-1:0] tape_len, mem_addr;
  logic [7:0]    mem_data;
  logic          casdout, busy, eot;

  cas_fsk_player #(.CLK_HZ(CLK_HZ), .RD_LAT(RD_LAT), .AW(AW)) dut (
    .clk(clk), .reset(reset), .en(en), .rewind(rewind), .tape_len(tape_len),
    .mem_addr(mem_addr), .mem_data(mem_data), .casdout(casdout), .busy(busy), .eot(eot)
  );

  always #5 clk = ~clk;

  // Two-stage SRAM model: address register then data register.
  logic [7:0]    mem [0:65535];
  logic [AW-1:0] addr_r;
  always @(posedge clk) begin
    addr_r   <= mem_addr;
    mem_data <= mem[addr_r];
  end

  typedef struct { int hi; int lo; } bit_exp_t;
  bit_exp_t exp_q[$];
  int checks = 0;
  int failures = 0;

  bit mon_on = 1'b0;
  int phase = 0;
  int hi_cnt = 0;
  int lo_cnt = 0;

  function automatic void push_byte(input logic [7:0] b, input bit last);
    bit_exp_t e;
    for (int i = 0; i < 8; i++) begin
      e.hi = b[i] ? H1 : H0;
      e.lo = e.hi + ((i == 7 && !last) ? GAP : 0);
      exp_q.push_back(e);
    end
  endfunction

  // Scoreboard monitor; paused cycles (en=0) are not counted.
  always @(negedge clk) begin
    bit done;
    int fh, fl;
    bit_exp_t e;
    done = 1'b0;
    fh = hi_cnt;
    fl = lo_cnt;
    if (mon_on) begin
      if (casdout === 1'b1) begin
        if (phase == 2) done = 1'b1;
        if (phase != 1) begin phase = 1; hi_cnt = 0; end
        hi_cnt += int'(en);
      end else if (busy === 1'b1) begin
        if (phase == 1) begin phase = 2; lo_cnt = 0; end
        if (phase == 2) lo_cnt += int'(en);
      end else begin
        if (phase == 2) done = 1'b1;
        phase = 0;
      end
      if (done) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL bit_unexpected hi=%0d lo=%0d at %0t", fh, fl, $time);
        end else begin
          e = exp_q.pop_front();
          if (fh !== e.hi || fl !== e.lo) begin
            failures++;
            $display("FAIL bit_timing got hi=%0d lo=%0d expected hi=%0d lo=%0d at %0t",
                     fh, fl, e.hi, e.lo, $time);
          end
        end
      end
    end
  end

  task automatic do_reset(input logic [AW-1:0] len);
    mon_on = 1'b0;
    exp_q.delete();
    phase = 0;
    reset = 1'b1;
    en = 1'b0;
    rewind = 1'b0;
    tape_len = len;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit timed_out);
    int n;
    n = 0;
    while (!(eot === 1'b1 && busy === 1'b0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    timed_out = (n >= budget);
    @(negedge clk);
  endtask

  task automatic wait_high(input int budget, output bit timed_out);
    int n;
    n = 0;
    @(negedge clk);
    while (casdout !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    timed_out = (n >= budget);
  endtask

  task automatic test_reset;
    reset = 1'b1;
    en = 1'b0;
    rewind = 1'b0;
    tape_len = 16'd5;
    @(negedge clk);
    checks++;
    if (mem_addr !== 16'd0 || casdout !== 1'b0 || busy !== 1'b0 || eot !== 1'b0) begin
      failures++;
      $display("FAIL reset_values got addr=%0d cas=%b busy=%b eot=%b expected 0/0/0/0",
               mem_addr, casdout, busy, eot);
    end
    @(posedge clk);
    #1 reset = 1'b0;
    repeat (4) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || eot !== 1'b0 || casdout !== 1'b0) begin
      failures++;
      $display("FAIL idle_no_en got busy=%b eot=%b cas=%b expected 0/0/0", busy, eot, casdout);
    end
  endtask

  task automatic test_single_byte;
    bit to;
    do_reset(16'd1);
    mem[0] = 8'h01;
    push_byte(8'h01, 1'b1);
    mon_on = 1'b1;
    en = 1'b1;
    wait_done(2000, to);
    checks++;
    if (to || exp_q.size() != 0 || eot !== 1'b1 || busy !== 1'b0 || mem_addr !== 16'd1) begin
      failures++;
      $display("FAIL single_end got timeout=%b left=%0d eot=%b busy=%b addr=%0d expected 0/0/1/0/1",
               to, exp_q.size(), eot, busy, mem_addr);
    end
  endtask

  task automatic test_back_to_back;
    bit to;
    int n;
    do_reset(16'd2);
    mem[0] = 8'hFF;
    mem[1] = 8'h00;
    push_byte(8'hFF, 1'b0);
    push_byte(8'h00, 1'b1);
    mon_on = 1'b1;
    en = 1'b1;
    wait_high(100, to);
    n = 0;
    while (eot !== 1'b1 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (to || n !== 480 + GAP) begin
      failures++;
      $display("FAIL b2b_eot_cycles got %0d expected %0d (timeout=%b)", n, 480 + GAP, to);
    end
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0 || mem_addr !== 16'd2 || busy !== 1'b0) begin
      failures++;
      $display("FAIL b2b_end got left=%0d addr=%0d busy=%b expected 0/2/0", exp_q.size(), mem_addr, busy);
    end
  endtask

  task automatic test_pause;
    bit to;
    int bad, n;
    do_reset(16'd1);
    mem[0] = 8'hA5;
    push_byte(8'hA5, 1'b1);
    mon_on = 1'b1;
    en = 1'b1;
    wait_high(100, to);
    repeat (5) @(posedge clk);
    #1 en = 1'b0;
    bad = 0;
    repeat (50) begin
      @(negedge clk);
      if (casdout !== 1'b1 || busy !== 1'b1) bad++;
    end
    checks++;
    if (to || bad !== 0) begin
      failures++;
      $display("FAIL pause_hold got bad_cycles=%0d timeout=%b expected 0/0", bad, to);
    end
    @(posedge clk);
    #1 en = 1'b1;
    n = 0;
    @(negedge clk);
    while (casdout === 1'b1 && n < 100) begin
      n++;
      @(negedge clk);
    end
    checks++;
    if (n !== H1 - 5) begin
      failures++;
      $display("FAIL pause_resume_high got %0d expected %0d", n, H1 - 5);
    end
    wait_done(2000, to);
    checks++;
    if (to || exp_q.size() != 0) begin
      failures++;
      $display("FAIL pause_end got timeout=%b left=%0d expected 0/0", to, exp_q.size());
    end
  endtask

  task automatic test_rewind;
    bit to;
    int n, bad;
    logic [7:0] pat [4];
    pat[0] = 8'h3C; pat[1] = 8'h81; pat[2] = 8'h5A; pat[3] = 8'hC3;
    do_reset(16'd4);
    for (int i = 0; i < 4; i++) begin
      mem[i] = pat[i];
      push_byte(pat[i], i == 3);
    end
    mon_on = 1'b1;
    en = 1'b1;
    n = 0;
    @(negedge clk);
    while (!(mem_addr === 16'd2 && casdout === 1'b1) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1 rewind = 1'b1;
    mon_on = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (n >= 3000 || mem_addr !== 16'd0 || casdout !== 1'b0 || busy !== 1'b0 || eot !== 1'b0) begin
      failures++;
      $display("FAIL rewind_next got addr=%0d cas=%b busy=%b eot=%b expected 0/0/0/0",
               mem_addr, casdout, busy, eot);
    end
    bad = 0;
    repeat (5) begin
      @(negedge clk);
      if (mem_addr !== 16'd0 || busy !== 1'b0 || casdout !== 1'b0) bad++;
    end
    checks++;
    if (bad !== 0) begin
      failures++;
      $display("FAIL rewind_hold got bad_cycles=%0d expected 0", bad);
    end
    exp_q.delete();
    phase = 0;
    for (int i = 0; i < 4; i++) push_byte(pat[i], i == 3);
    mon_on = 1'b1;
    @(posedge clk);
    #1 rewind = 1'b0;
    wait_done(4000, to);
    checks++;
    if (to || exp_q.size() != 0 || mem_addr !== 16'd4) begin
      failures++;
      $display("FAIL rewind_replay got timeout=%b left=%0d addr=%0d expected 0/0/4",
               to, exp_q.size(), mem_addr);
    end
  endtask

  task automatic test_zero_len;
    int bad;
    do_reset(16'd0);
    en = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (eot !== 1'b1) begin
      failures++;
      $display("FAIL zero_len_eot got %b expected 1", eot);
    end
    bad = 0;
    repeat (1000) begin
      @(negedge clk);
      if (casdout !== 1'b0 || busy !== 1'b0 || eot !== 1'b1) bad++;
    end
    checks++;
    if (bad !== 0) begin
      failures++;
      $display("FAIL zero_len_idle got bad_cycles=%0d expected 0", bad);
    end
  endtask

  task automatic test_shrink;
    bit to;
    do_reset(16'd3);
    mem[0] = 8'h96; mem[1] = 8'h11; mem[2] = 8'h22;
    push_byte(8'h96, 1'b1);
    mon_on = 1'b1;
    en = 1'b1;
    wait_high(100, to);
    @(posedge clk);
    #1 tape_len = 16'd0;
    wait_done(2000, to);
    checks++;
    if (to || exp_q.size() != 0 || mem_addr !== 16'd1 || eot !== 1'b1) begin
      failures++;
      $display("FAIL shrink_end got timeout=%b left=%0d addr=%0d eot=%b expected 0/0/1/1",
               to, exp_q.size(), mem_addr, eot);
    end
  endtask

  task automatic test_autorewind;
    bit to;
    do_reset(16'd2);
    mem[0] = 8'hC3; mem[1] = 8'h3C;
    push_byte(8'hC3, 1'b0);
    push_byte(8'h3C, 1'b1);
    mon_on = 1'b1;
    en = 1'b1;
    wait_done(2000, to);
    checks++;
    if (to || exp_q.size() != 0 || mem_addr !== 16'd2 || eot !== 1'b1) begin
      failures++;
      $display("FAIL autorew_play got timeout=%b left=%0d addr=%0d eot=%b expected 0/0/2/1",
               to, exp_q.size(), mem_addr, eot);
    end
    @(posedge clk);
    #1 en = 1'b0;
    @(posedge clk);
    @(negedge clk);
`ifdef CAS_AUTOREWIND_EN
    checks++;
    if (mem_addr !== 16'd0 || eot !== 1'b0) begin
      failures++;
      $display("FAIL autorew_on got addr=%0d eot=%b expected 0/0", mem_addr, eot);
    end
`else
    repeat (5) @(negedge clk);
    checks++;
    if (mem_addr !== 16'd2 || eot !== 1'b1) begin
      failures++;
      $display("FAIL autorew_off got addr=%0d eot=%b expected 2/1", mem_addr, eot);
    end
`endif
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    test_reset();
    test_single_byte();
    test_back_to_back();
    test_pause();
    test_rewind();
    test_zero_len();
    test_shrink();
    test_autorewind();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
